// File: rtl/yuv_fb_pkg.sv
// Shared constants and FSM state type for the YUV 4:2:0 frame-buffer reader.
package yuv_fb_pkg;

    localparam int unsigned Y_SAMPLES_PER_WORD = 5;
    localparam int unsigned C_SAMPLES_PER_WORD = 18;
    localparam int unsigned Y_WORD_W           = 40;
    localparam int unsigned C_WORD_W           = 144;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD2,
        STREAM,
        DONE
    } fb_state_e;

endpackage

// File: rtl/packed_lane_unpacker.sv
// One plane lane: line-base tracking, cur/nxt word pair, sample offset and
// read-address sequencing for a buffer holding SAMPLES bytes per word.
module packed_lane_unpacker #(
    parameter int unsigned SAMPLES = 5,
    parameter int unsigned AW      = 16,
    parameter int unsigned LINE    = 640
) (
    input  logic                   MIPI_PIXEL_CLK,
    input  logic                   RESET_N,
    input  logic                   clear_base,
    input  logic                   next_line,
    input  logic                   load,
    input  logic                   load2,
    input  logic                   step,
    input  logic [SAMPLES*8-1:0]   q,
    output logic [AW-1:0]          rdaddress,
    output logic [7:0]             sample
);

    localparam int unsigned    OW         = $clog2(SAMPLES);
    localparam logic [AW-1:0]  LINE_WORDS = AW'(LINE / SAMPLES);
    localparam logic [OW:0]    LINE_REM   = (OW+1)'(LINE % SAMPLES);
    localparam logic [OW:0]    N_EXT      = (OW+1)'(SAMPLES);
    localparam logic [OW-1:0]  LAST_OFF   = OW'(SAMPLES - 1);

    logic [SAMPLES*8-1:0] cur, nxt;
    logic [AW-1:0]        addr, base_word;
    logic [OW-1:0]        off, base_off;
    logic                 pend0, pend1;
    logic [OW:0]          off_sum;

    assign off_sum   = {1'b0, base_off} + LINE_REM;
    assign rdaddress = load ? base_word : addr;
    assign sample    = cur[{off, 3'b000} +: 8];

    // pend0/pend1 track a read in flight: address driven one cycle, data the
    // next; a wrap that lands while data is still on q takes it straight from q.
    always_ff @(posedge MIPI_PIXEL_CLK) begin
        if (!RESET_N) begin
            cur       <= '0;
            nxt       <= '0;
            addr      <= '0;
            base_word <= '0;
            off       <= '0;
            base_off  <= '0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
        end else begin
            pend1 <= pend0;
            pend0 <= 1'b0;
            if (pend1)
                nxt <= q;

            if (clear_base) begin
                base_word <= '0;
                base_off  <= '0;
            end else if (next_line) begin
                if (off_sum >= N_EXT) begin
                    base_off  <= OW'(off_sum - N_EXT);
                    base_word <= base_word + LINE_WORDS + 1'b1;
                end else begin
                    base_off  <= off_sum[OW-1:0];
                    base_word <= base_word + LINE_WORDS;
                end
            end

            if (load) begin
                addr  <= base_word + 1'b1;
                off   <= base_off;
                pend0 <= 1'b1;
            end else if (load2) begin
                cur <= q;
            end else if (step) begin
                if (off == LAST_OFF) begin
                    off   <= '0;
                    cur   <= pend1 ? q : nxt;
                    addr  <= addr + 1'b1;
                    pend0 <= 1'b1;
                end else begin
                    off <= off + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/yuv420_fb_reader.sv
// Reads packed planar YUV 4:2:0 frame buffers and streams raster-order {Y,U,V}
// pixels over valid/ready. Optional test pattern: `define YUV_FB_RDR_PATTERN_EN.
module yuv420_fb_reader
    import yuv_fb_pkg::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned Y_AW   = 16,
    parameter int unsigned C_AW   = 13
) (
    input  logic                MIPI_PIXEL_CLK,
    input  logic                RESET_N,
    input  logic                frame_start,
`ifdef YUV_FB_RDR_PATTERN_EN
    input  logic                pattern_sel,
`endif
    output logic                busy,
    output logic                frame_done,
    output logic [Y_AW-1:0]     y_rdaddress,
    input  logic [Y_WORD_W-1:0] y_q,
    output logic [C_AW-1:0]     u_rdaddress,
    input  logic [C_WORD_W-1:0] u_q,
    output logic [C_AW-1:0]     v_rdaddress,
    input  logic [C_WORD_W-1:0] v_q,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [7:0]          pix_y,
    output logic [7:0]          pix_u,
    output logic [7:0]          pix_v,
    output logic                pix_sof,
    output logic                pix_eol
);

    localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);

    fb_state_e   state_q, state_d;
    logic [15:0] row, col;
    logic        pat_q;
    logic        start, xfer, eol, last_row, y_line, c_line, c_step;
    logic [Y_AW-1:0] y_addr;
    logic [C_AW-1:0] u_addr, v_addr;
    logic [7:0]  y_s, u_s, v_s;

    assign start    = (state_q == IDLE) && frame_start;
    assign xfer     = (state_q == STREAM) && pix_ready;
    assign eol      = (col == LAST_COL);
    assign last_row = (row == LAST_ROW);
    assign y_line   = xfer && eol && !last_row;
    assign c_line   = y_line && row[0];
    assign c_step   = xfer && col[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = LOAD;
            LOAD:    state_d = LOAD2;
            LOAD2:   state_d = STREAM;
            STREAM:  if (xfer && eol) state_d = last_row ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MIPI_PIXEL_CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            row     <= '0;
            col     <= '0;
            pat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                row <= '0;
                col <= '0;
`ifdef YUV_FB_RDR_PATTERN_EN
                pat_q <= pattern_sel;
`endif
            end else if (xfer) begin
                if (eol) begin
                    col <= '0;
                    if (!last_row)
                        row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    packed_lane_unpacker #(.SAMPLES(Y_SAMPLES_PER_WORD), .AW(Y_AW), .LINE(WIDTH)) u_y_lane (
        .MIPI_PIXEL_CLK(MIPI_PIXEL_CLK), .RESET_N(RESET_N), .clear_base(start),
        .next_line(y_line), .load(state_q == LOAD), .load2(state_q == LOAD2),
        .step(xfer), .q(y_q), .rdaddress(y_addr), .sample(y_s)
    );

    packed_lane_unpacker #(.SAMPLES(C_SAMPLES_PER_WORD), .AW(C_AW), .LINE(WIDTH / 2)) u_u_lane (
        .MIPI_PIXEL_CLK(MIPI_PIXEL_CLK), .RESET_N(RESET_N), .clear_base(start),
        .next_line(c_line), .load(state_q == LOAD), .load2(state_q == LOAD2),
        .step(c_step), .q(u_q), .rdaddress(u_addr), .sample(u_s)
    );

    packed_lane_unpacker #(.SAMPLES(C_SAMPLES_PER_WORD), .AW(C_AW), .LINE(WIDTH / 2)) u_v_lane (
        .MIPI_PIXEL_CLK(MIPI_PIXEL_CLK), .RESET_N(RESET_N), .clear_base(start),
        .next_line(c_line), .load(state_q == LOAD), .load2(state_q == LOAD2),
        .step(c_step), .q(v_q), .rdaddress(v_addr), .sample(v_s)
    );

    assign busy        = (state_q != IDLE);
    assign frame_done  = (state_q == DONE);
    assign pix_valid   = (state_q == STREAM);
    assign pix_sof     = pix_valid && (row == '0) && (col == '0);
    assign pix_eol     = pix_valid && eol;
    assign pix_y       = !pix_valid ? '0 : (pat_q ? col[7:0] : y_s);
    assign pix_u       = !pix_valid ? '0 : (pat_q ? row[7:0] : u_s);
    assign pix_v       = !pix_valid ? '0 : (pat_q ? 8'h80    : v_s);
    assign y_rdaddress = pat_q ? '0 : y_addr;
    assign u_rdaddress = pat_q ? '0 : u_addr;
    assign v_rdaddress = pat_q ? '0 : v_addr;

endmodule

// File: tb/tb_yuv420_fb_reader.sv
// Directed bench for yuv420_fb_reader at WIDTH=40, HEIGHT=4 with synthetic plane memories.
module tb_yuv420_fb_reader;

    localparam int W = 40;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_start = 1'b0;
    logic         pix_ready = 1'b0;
`ifdef YUV_FB_RDR_PATTERN_EN
    logic         pattern_sel = 1'b0;
`endif
    logic         busy, frame_done, pix_valid, pix_sof, pix_eol;
    logic [15:0]  y_rdaddress;
    logic [12:0]  u_rdaddress, v_rdaddress;
    logic [39:0]  y_q = '0;
    logic [143:0] u_q = '0, v_q = '0;
    logic [7:0]   pix_y, pix_u, pix_v;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    yuv420_fb_reader #(.WIDTH(W), .HEIGHT(H), .Y_AW(16), .C_AW(13)) dut (
        .MIPI_PIXEL_CLK(clk), .RESET_N(rst_n), .frame_start(frame_start),
`ifdef YUV_FB_RDR_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .busy(busy), .frame_done(frame_done),
        .y_rdaddress(y_rdaddress), .y_q(y_q),
        .u_rdaddress(u_rdaddress), .u_q(u_q),
        .v_rdaddress(v_rdaddress), .v_q(v_q),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_y(pix_y), .pix_u(pix_u), .pix_v(pix_v),
        .pix_sof(pix_sof), .pix_eol(pix_eol)
    );

    // Y byte k of word a holds 5a+k; U sample k of word w holds 18w+k; V is U+100.
    function automatic logic [39:0] y_word(input logic [15:0] a);
        logic [39:0] w;
        for (int k = 0; k < 5; k++) w[8*k +: 8] = 8'(5 * int'(a) + k);
        return w;
    endfunction

    function automatic logic [143:0] c_word(input logic [12:0] a, input int bias);
        logic [143:0] w;
        for (int k = 0; k < 18; k++) w[8*k +: 8] = 8'(18 * int'(a) + k + bias);
        return w;
    endfunction

    always @(posedge clk) begin
        y_q <= y_word(y_rdaddress);
        u_q <= c_word(u_rdaddress, 0);
        v_q <= c_word(v_rdaddress, 100);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input bit rnd, input int reset_at, input int pulse_at,
                             input bit pat, input bit fs_on_done);
        int n = 0, gap = 0, r, c, ci;
        bit after_eol = 0, stalled = 0, done_seen = 0, finished = 0, pulsed = 0, quiet_bad;
        logic [28:0] held;
        logic [7:0] ey, eu, ev;
        frame_start = 1'b1;
`ifdef YUV_FB_RDR_PATTERN_EN
        pattern_sel = pat;
`endif
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (done_seen) begin
                chk("busy_after_done", {busy, pix_valid}, 0);
                finished = 1;
                break;
            end
            if (frame_done) begin
                chk("pixels_at_done", n, W * H);
                done_seen = 1;
                if (fs_on_done) frame_start = 1'b1;
                continue;
            end
            if (cyc == 1) chk("busy_start", busy, 1);
            if (cyc == 3) chk("first_valid_latency", pix_valid, 1);
            if (reset_at >= 0 && n == reset_at) begin
                rst_n = 1'b0;
                pix_ready = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                chk("rst_ctrl", {busy, frame_done, pix_valid, pix_sof, pix_eol}, 0);
                chk("rst_pix", {pix_y, pix_u, pix_v}, 0);
                chk("rst_addr", {y_rdaddress, u_rdaddress, v_rdaddress}, 0);
                quiet_bad = 0;
                repeat (6) begin
                    @(negedge clk);
                    quiet_bad |= frame_done | pix_valid | busy;
                end
                chk("rst_abandon", quiet_bad, 0);
                return;
            end
            if (pulse_at >= 0 && n == pulse_at && !pulsed) begin
                frame_start = 1'b1;
                pulsed = 1;
            end
            if (stalled)
                chk("stall_hold", {pix_valid, pix_sof, pix_eol, pix_y, pix_u, pix_v, 2'b00}, held);
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_valid) begin
                if (after_eol) chk("line_gap", gap, 2);
                after_eol = 0;
            end else if (after_eol) begin
                gap++;
            end
            if (pix_valid && pix_ready) begin
                r  = n / W;
                c  = n % W;
                ci = (r / 2) * (W / 2) + c / 2;
                ey = pat ? 8'(c) : 8'(n);
                eu = pat ? 8'(r) : 8'(ci);
                ev = pat ? 8'h80 : 8'(ci + 100);
                chk($sformatf("y_px%0d", n), pix_y, ey);
                chk($sformatf("u_px%0d", n), pix_u, eu);
                chk($sformatf("v_px%0d", n), pix_v, ev);
                chk($sformatf("sof_eol_px%0d", n), {pix_sof, pix_eol}, {n == 0, c == W - 1});
                if (pat) chk("pat_addr_zero", {y_rdaddress, u_rdaddress, v_rdaddress}, 0);
                if (c == W - 1) begin
                    after_eol = 1;
                    gap = 0;
                end
                n++;
            end
            stalled = pix_valid && !pix_ready;
            held = {pix_valid, pix_sof, pix_eol, pix_y, pix_u, pix_v, 2'b00};
        end
        chk("frame_timeout", finished, 1);
        frame_start = 1'b0;
        quiet_bad = 0;
        repeat (6) begin
            @(negedge clk);
            quiet_bad |= frame_done | pix_valid | busy;
        end
        chk("idle_after_frame", quiet_bad, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, frame_done, pix_valid, pix_sof, pix_eol}, 0);
        chk("reset_pix", {pix_y, pix_u, pix_v}, 0);
        chk("reset_addr", {y_rdaddress, u_rdaddress, v_rdaddress}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ready tied high; a frame_start coinciding with frame_done is dropped.
        run_frame(0, -1, -1, 0, 1);
        // Random backpressure.
        run_frame(1, -1, -1, 0, 0);
        // Reset at pixel 70, then a clean restart from pixel 0.
        run_frame(0, 70, -1, 0, 0);
        run_frame(0, -1, -1, 0, 0);
        // Mid-frame frame_start ignored.
        run_frame(0, -1, 10, 0, 0);
`ifdef YUV_FB_RDR_PATTERN_EN
        run_frame(1, -1, -1, 1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
